// File: rtl/tlb_idma_mux.sv
// tlb_idma_mux: round-robin arbiter from N TLB requesters onto one IDMA engine, with completion routing.
module tlb_idma_mux #(
   parameter int N_CHAN    = 2,
   parameter int SEQ_DEPTH = 8,
   parameter int REQ_BITS  = 192,
   parameter int CW        = (N_CHAN > 1) ? $clog2(N_CHAN) : 1,
   parameter int OW        = $clog2(SEQ_DEPTH + 1)
) (
   input  logic                       aclk,
   input  logic                       areset,
   input  logic                       lock_en,
   input  logic [CW-1:0]              lock_chan,
   input  logic [N_CHAN-1:0]          s_valid,
   output logic [N_CHAN-1:0]          s_ready,
   input  logic [N_CHAN*REQ_BITS-1:0] s_req,
   input  logic [N_CHAN-1:0]          s_ctl,
   input  logic [N_CHAN-1:0]          s_isr,
   output logic [N_CHAN-1:0]          s_done,
   output logic [N_CHAN-1:0]          s_isr_return,
   output logic                       m_valid,
   input  logic                       m_ready,
   output logic [REQ_BITS-1:0]        m_req,
   output logic                       m_ctl,
   output logic                       m_isr,
   input  logic                       m_done,
   output logic [OW-1:0]              outstanding,
   output logic                       err_unexp_done
);
   localparam int PW = $clog2(SEQ_DEPTH);
   localparam logic [0:0] IDLE = 1'b0, GRANT = 1'b1;
   logic [0:0]        state;
   logic [CW-1:0]     gnt, last, pick, idx, head_id;
   logic [N_CHAN-1:0] elig;
   logic              full, empty, hs, push, pop, head_isr;
   logic [PW:0]       wp, rp;
   logic [CW-1:0]     fid [SEQ_DEPTH];
   logic              fisr [SEQ_DEPTH];
   assign elig = s_valid & (lock_en ? (N_CHAN'(1) << lock_chan) : {N_CHAN{1'b1}});
   always_comb begin
      pick = '0;
      idx  = '0;
      for (int i = N_CHAN; i >= 1; i--) begin
         idx = CW'((int'(last) + i) % N_CHAN);
         pick = elig[idx] ? idx : pick;
      end
   end
   assign full         = (wp[PW] != rp[PW]) && (wp[PW-1:0] == rp[PW-1:0]);
   assign empty        = (wp == rp);
   assign m_valid      = (state == GRANT) && s_valid[gnt] && !(s_ctl[gnt] && full);
   assign hs           = m_valid && m_ready;
   assign push         = hs && s_ctl[gnt];
   assign pop          = m_done && !empty;
   assign head_id      = fid[rp[PW-1:0]];
   assign head_isr     = fisr[rp[PW-1:0]];
   assign m_req        = s_req[gnt*REQ_BITS +: REQ_BITS];
   assign m_ctl        = s_ctl[gnt];
   assign m_isr        = 1'b0;
   assign s_ready      = hs ? (N_CHAN'(1) << gnt) : '0;
   assign s_done       = pop ? (N_CHAN'(1) << head_id) : '0;
   assign s_isr_return = (pop && head_isr) ? (N_CHAN'(1) << head_id) : '0;
   assign outstanding  = OW'(wp - rp);
   always_ff @(posedge aclk) begin
      if (areset) begin
         state          <= IDLE;
         gnt            <= '0;
         last           <= CW'(N_CHAN - 1);
         wp             <= '0;
         rp             <= '0;
         err_unexp_done <= 1'b0;
      end else begin
         if (push) wp <= wp + 1'b1;
         if (pop) rp <= rp + 1'b1;
         if (m_done && empty) err_unexp_done <= 1'b1;
         if (state == IDLE) begin
            if (|elig) begin
               gnt   <= pick;
               state <= GRANT;
            end
         end else if (hs) begin
            last  <= gnt;
            state <= IDLE;
         end else if (!s_valid[gnt]) begin
            state <= IDLE;
         end
      end
   end
   always_ff @(posedge aclk) begin
      if (push) begin
         fid[wp[PW-1:0]]  <= gnt;
         fisr[wp[PW-1:0]] <= s_isr[gnt];
      end
   end
endmodule

// File: tb/tb_tlb_idma_mux.sv
// tb_tlb_idma_mux: directed checks of arbitration, lock, completion routing, full FIFO, backpressure and reset.
module tb_tlb_idma_mux;
   localparam int N = 4, D = 4, RB = 16, CW = 2, OW = 3;
   logic          aclk = 1'b0, areset = 1'b1, lock_en = 1'b0, m_ready = 1'b0, m_done = 1'b0;
   logic [CW-1:0] lock_chan = '0;
   logic [N-1:0]  s_valid = '0, s_ctl = '0, s_isr = '0;
   logic [N-1:0]  s_ready, s_done, s_isr_return;
   logic [N*RB-1:0] s_req;
   logic          m_valid, m_ctl, m_isr, err_unexp_done;
   logic [RB-1:0] m_req;
   logic [OW-1:0] outstanding;
   int vec = 0, errs = 0;

   tlb_idma_mux #(.N_CHAN(N), .SEQ_DEPTH(D), .REQ_BITS(RB)) dut (
      .aclk(aclk), .areset(areset), .lock_en(lock_en), .lock_chan(lock_chan),
      .s_valid(s_valid), .s_ready(s_ready), .s_req(s_req), .s_ctl(s_ctl), .s_isr(s_isr),
      .s_done(s_done), .s_isr_return(s_isr_return), .m_valid(m_valid), .m_ready(m_ready),
      .m_req(m_req), .m_ctl(m_ctl), .m_isr(m_isr), .m_done(m_done),
      .outstanding(outstanding), .err_unexp_done(err_unexp_done)
   );

   always #5 aclk = ~aclk;

   function automatic logic [RB-1:0] rq(int i);
      return RB'(16'h1000 * (i + 1) + i);
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vec++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge aclk);
      #1;
   endtask

   task automatic send(input int ch, input logic ctl, input logic isr);
      s_valid = N'(1) << ch;
      s_ctl[ch] = ctl;
      s_isr[ch] = isr;
      m_ready = 1'b1;
      tick();
      chk("send_ready", 32'(s_ready), 32'(N'(1) << ch));
      chk("send_req", 32'(m_req), 32'(rq(ch)));
      tick();
      s_valid = '0;
      #1;
   endtask

   task automatic chk_idle_outputs(input string tag);
      chk({tag, "_mvalid"}, 32'(m_valid), 0);
      chk({tag, "_sready"}, 32'(s_ready), 0);
      chk({tag, "_sdone"}, 32'(s_done), 0);
      chk({tag, "_isrret"}, 32'(s_isr_return), 0);
      chk({tag, "_outst"}, 32'(outstanding), 0);
      chk({tag, "_misr"}, 32'(m_isr), 0);
      chk({tag, "_err"}, 32'(err_unexp_done), 0);
   endtask

   initial begin
      for (int i = 0; i < N; i++) s_req[i*RB +: RB] = rq(i);
      tick();
      tick();
      areset = 1'b0;
      #1;
      chk_idle_outputs("reset");
      // round robin, ctl=0
      s_valid = 4'hF;
      m_ready = 1'b1;
      #1;
      chk("rr_idle_mvalid", 32'(m_valid), 0);
      for (int k = 0; k < 5; k++) begin
         tick();
         chk("rr_ready", 32'(s_ready), 32'(N'(1) << (k % N)));
         chk("rr_req", 32'(m_req), 32'(rq(k % N)));
         chk("rr_outst", 32'(outstanding), 0);
         tick();
         chk("rr_gap", 32'(s_ready), 0);
      end
      s_valid = '0;
      tick();
      // lock to channel 2 while 0 and 2 request; last=0
      lock_en = 1'b1;
      lock_chan = 2'd2;
      s_valid = 4'b0101;
      tick();
      chk("lock_ready1", 32'(s_ready), 32'h4);
      tick();
      tick();
      chk("lock_ready2", 32'(s_ready), 32'h4);
      tick();
      m_ready = 1'b0;
      tick();
      chk("lock_grant_mvalid", 32'(m_valid), 1);
      chk("lock_grant_req", 32'(m_req), 32'(rq(2)));
      chk("lock_grant_noready", 32'(s_ready), 0);
      lock_en = 1'b0;
      m_ready = 1'b1;
      #1;
      chk("unlock_completes", 32'(s_ready), 32'h4);
      tick();
      tick();
      chk("unlock_next_ch0", 32'(s_ready), 32'h1);
      tick();
      s_valid = '0;
      s_ctl = '0;
      #1;
      // completion routing
      send(1, 1'b1, 1'b1);
      chk("cr_outst1", 32'(outstanding), 1);
      send(0, 1'b1, 1'b0);
      send(3, 1'b0, 1'b0);
      chk("cr_outst2", 32'(outstanding), 2);
      m_done = 1'b1;
      #1;
      chk("cr_done1", 32'(s_done), 32'h2);
      chk("cr_isr1", 32'(s_isr_return), 32'h2);
      tick();
      chk("cr_outst_a", 32'(outstanding), 1);
      chk("cr_done2", 32'(s_done), 32'h1);
      chk("cr_isr2", 32'(s_isr_return), 0);
      tick();
      chk("cr_outst_b", 32'(outstanding), 0);
      chk("cr_done3", 32'(s_done), 0);
      chk("cr_err_before", 32'(err_unexp_done), 0);
      tick();
      m_done = 1'b0;
      #1;
      chk("cr_err", 32'(err_unexp_done), 1);
      // full FIFO
      areset = 1'b1;
      tick();
      areset = 1'b0;
      #1;
      chk("full_err_cleared", 32'(err_unexp_done), 0);
      for (int c = 0; c < 4; c++) send(c, 1'b1, 1'(c & 1));
      chk("full_outst4", 32'(outstanding), 4);
      s_valid = 4'b0001;
      s_ctl[0] = 1'b1;
      tick();
      chk("full_blocked", 32'(m_valid), 0);
      m_done = 1'b1;
      #1;
      chk("full_blocked_done", 32'(m_valid), 0);
      chk("full_pop_done", 32'(s_done), 32'h1);
      chk("full_pop_isr", 32'(s_isr_return), 0);
      tick();
      m_done = 1'b0;
      #1;
      chk("full_after_pop_outst", 32'(outstanding), 3);
      chk("full_after_pop_ready", 32'(s_ready), 32'h1);
      tick();
      chk("full_refill", 32'(outstanding), 4);
      s_valid = '0;
      #1;
      send(2, 1'b0, 1'b0);
      chk("full_ctl0_outst", 32'(outstanding), 4);
      // backpressure
      s_valid = 4'b0010;
      s_ctl[1] = 1'b0;
      m_ready = 1'b0;
      tick();
      for (int k = 0; k < 5; k++) begin
         chk("bp_mvalid", 32'(m_valid), 1);
         chk("bp_req", 32'(m_req), 32'(rq(1)));
         chk("bp_ready", 32'(s_ready), 0);
         tick();
      end
      m_ready = 1'b1;
      #1;
      chk("bp_hs", 32'(s_ready), 32'h2);
      tick();
      s_valid = '0;
      #1;
      chk("bp_after_ready", 32'(s_ready), 0);
      chk("bp_after_mvalid", 32'(m_valid), 0);
      tick();
      chk("bp_single_hs", 32'(s_ready), 0);
      // reset mid-grant with three outstanding
      m_done = 1'b1;
      tick();
      m_done = 1'b0;
      s_valid = 4'b0100;
      s_ctl[2] = 1'b1;
      m_ready = 1'b0;
      tick();
      chk("rst_pre_outst", 32'(outstanding), 3);
      chk("rst_pre_mvalid", 32'(m_valid), 1);
      areset = 1'b1;
      tick();
      areset = 1'b0;
      #1;
      chk_idle_outputs("rst_mid");
      s_valid = '0;
      m_done = 1'b1;
      #1;
      chk("rst_done_none", 32'(s_done), 0);
      tick();
      m_done = 1'b0;
      #1;
      chk("rst_err", 32'(err_unexp_done), 1);
      $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
      $finish;
   end
endmodule
